// File: rtl/instr_encode_loader_pkg.sv
// Shared opcodes, class codes, funct3 values and immediate bounds
// for the IMEM program loader.
package instr_encode_loader_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LW     = 7'b0000011;
  localparam logic [6:0] OPC_SW     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    OPC_CLS_R    = 3'd0,
    OPC_CLS_ADDI = 3'd1,
    OPC_CLS_LW   = 3'd2,
    OPC_CLS_SW   = 3'd3,
    OPC_CLS_BEQ  = 3'd4,
    OPC_CLS_BNE  = 3'd5,
    OPC_CLS_JAL  = 3'd6
  } opc_cls_e;

  localparam logic [2:0] FUNCT3_ADDI = 3'b000;
  localparam logic [2:0] FUNCT3_LW   = 3'b010;
  localparam logic [2:0] FUNCT3_SW   = 3'b010;
  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_OP    = 2'b11;

  function automatic logic in_rng(
    logic [31:0] v,
    int          lo,
    int          hi
  );
    return ($signed(v) >= lo) &&
           ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_encode_loader_pack.sv
// Combinational descriptor packer: range/alignment checks plus
// RV32I field placement for the supported instruction subset.
module instr_pack
  import instr_encode_loader_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        err_valid_o,
  output logic [1:0]  err_code_o
);

  logic [6:0] f7;
  logic       ok12;
  logic       ok13;
  logic       ok21;

  assign f7   = {1'b0, funct7b5_i, 5'b0};
  assign ok12 = in_rng(imm_i, IMM12_MIN, IMM12_MAX);
  assign ok13 = in_rng(imm_i, IMM13_MIN, IMM13_MAX);
  assign ok21 = in_rng(imm_i, IMM21_MIN, IMM21_MAX);

  always_comb begin
    word_o      = '0;
    err_code_o  = ERR_NONE;
    unique case (op_i)
      OPC_CLS_R: begin
        word_o = {f7, rs2_i, rs1_i, funct3_i,
                  rd_i, OPC_RTYPE};
      end
      OPC_CLS_ADDI: begin
        if (!ok12) err_code_o = ERR_RANGE;
        word_o = {imm_i[11:0], rs1_i, FUNCT3_ADDI,
                  rd_i, OPC_ITYPE};
      end
      OPC_CLS_LW: begin
        if (!ok12) err_code_o = ERR_RANGE;
        word_o = {imm_i[11:0], rs1_i, FUNCT3_LW,
                  rd_i, OPC_LW};
      end
      OPC_CLS_SW: begin
        if (!ok12) err_code_o = ERR_RANGE;
        word_o = {imm_i[11:5], rs2_i, rs1_i, FUNCT3_SW,
                  imm_i[4:0], OPC_SW};
      end
      OPC_CLS_BEQ, OPC_CLS_BNE: begin
        // alignment is checked last so it wins over range
        if (!ok13)    err_code_o = ERR_RANGE;
        if (imm_i[0]) err_code_o = ERR_ALIGN;
        word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i,
                  (op_i == OPC_CLS_BNE) ? FUNCT3_BNE
                                        : FUNCT3_BEQ,
                  imm_i[4:1], imm_i[11], OPC_BRANCH};
      end
      OPC_CLS_JAL: begin
        if (!ok21)    err_code_o = ERR_RANGE;
        if (imm_i[0]) err_code_o = ERR_ALIGN;
        word_o = {imm_i[20], imm_i[10:1], imm_i[11],
                  imm_i[19:12], rd_i, OPC_JAL};
      end
      default: err_code_o = ERR_OP;
    endcase
  end

  assign err_valid_o = (err_code_o != ERR_NONE);

endmodule

// File: rtl/instr_encode_loader.sv
// Descriptor handshake, IMEM write stage, pointer, count, full and
// sticky error state around the combinational packer.
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int BASE  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [2:0]    in_funct3,
  input  logic          in_funct7b5,
  input  logic [31:0]   in_imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam logic [AW-1:0] BASE_C  = AW'(BASE);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  logic [31:0]   word;
  logic          perr;
  logic [1:0]    pcode;
  logic          accept;
  logic [AW:0]   cnt_inc;

  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;

  instr_pack u_pack (
    .op_i        (in_op),
    .rd_i        (in_rd),
    .rs1_i       (in_rs1),
    .rs2_i       (in_rs2),
    .funct3_i    (in_funct3),
    .funct7b5_i  (in_funct7b5),
    .imm_i       (in_imm),
    .word_o      (word),
    .err_valid_o (perr),
    .err_code_o  (pcode)
  );

  assign in_ready = !full_q && !clear;
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    err_d   = err_q;
    code_d  = code_q;
    if (clear) begin
      ptr_d  = BASE_C;
      cnt_d  = '0;
      full_d = 1'b0;
      err_d  = 1'b0;
      code_d = ERR_NONE;
    end else if (accept) begin
      if (perr) begin
        err_d = 1'b1;
        if (!err_q) code_d = pcode;
      end else begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = word;
        ptr_d   = ptr_q + 1'b1;
        cnt_d   = cnt_inc;
        full_d  = (cnt_inc == DEPTH_C);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= BASE_C;
      wdata_q <= '0;
      ptr_q   <= BASE_C;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = cnt_q;
  assign full       = full_q;
  assign err        = err_q;
  assign err_code   = code_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Vector table plus write scoreboard for the IMEM loader,
// run on a 4-word instance so the full boundary is reachable.
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_imm;
  logic        imem_we;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [2:0]  count;
  logic        full;
  logic        err;
  logic [1:0]  err_code;

  instr_encode_loader #(.DEPTH(4), .AW(2), .BASE(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_imm      (in_imm),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .count       (count),
    .full        (full),
    .err         (err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;
    logic [31:0] word;
    logic [1:0]  code;
  } vec_t;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_cnt = 0;
  logic [1:0] exp_ptr = 2'd0;

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0d data %h",
                 imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.addr));
        chk("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic add(logic [2:0] op, logic [4:0] rd,
                     logic [4:0] rs1, logic [4:0] rs2,
                     logic [2:0] f3, logic f7b5,
                     logic [31:0] imm, logic [31:0] word,
                     logic [1:0] code);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7b5 = f7b5; v.imm = imm;
    v.word = word; v.code = code;
    vecs.push_back(v);
  endtask

  task automatic drive(vec_t v);
    in_op = v.op; in_rd = v.rd; in_rs1 = v.rs1;
    in_rs2 = v.rs2; in_funct3 = v.f3;
    in_funct7b5 = v.f7b5; in_imm = v.imm;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(vec_t v, logic push);
    if (push && v.code == 2'b00) begin
      sb.push_back('{addr: exp_ptr, data: v.word});
      exp_ptr = exp_ptr + 2'd1;
      exp_cnt++;
    end
    drive(v);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear = 1'b1;
    #1;
    chk("ready_in_clear", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    exp_ptr = 2'd0;
    exp_cnt = 0;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_err", {29'd0, err, err_code}, 32'd0);
    chk("clr_full", 32'(full), 32'd0);
  endtask

  function automatic vec_t mk(logic [2:0] op, logic [4:0] rd,
                              logic [4:0] rs1, logic [4:0] rs2,
                              logic [31:0] imm,
                              logic [31:0] word,
                              logic [1:0] code);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = 3'd0; v.f7b5 = 1'b0; v.imm = imm;
    v.word = word; v.code = code;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7b5 = 1'b0; in_imm = '0;

    add(3'd1, 5, 0, 0, 0, 0, -32'sd1, 32'hFFF00293, 2'b00);
    add(3'd0, 3, 1, 2, 0, 1, 0, 32'h402081B3, 2'b00);
    add(3'd3, 0, 1, 2, 0, 0, 8, 32'h0020A423, 2'b00);
    add(3'd5, 0, 1, 2, 0, 0, -32'sd4, 32'hFE209EE3, 2'b00);
    add(3'd6, 1, 0, 0, 0, 0, 2048, 32'h001000EF, 2'b00);
    add(3'd5, 0, 1, 2, 0, 0, 3, 32'h0, 2'b10);
    add(3'd0, 5, 6, 7, 0, 0, 0, 32'h007302B3, 2'b00);
    add(3'd2, 4, 2, 0, 0, 0, -32'sd8, 32'hFF812203, 2'b00);
    add(3'd4, 0, 0, 0, 0, 0, 8, 32'h00000463, 2'b00);
    add(3'd1, 0, 0, 0, 0, 0, 2048, 32'h0, 2'b01);
    add(3'd1, 1, 1, 0, 0, 0, 2047, 32'h7FF08093, 2'b00);
    add(3'd4, 0, 1, 2, 0, 0, -32'sd4096, 32'h80208063, 2'b00);
    add(3'd4, 0, 1, 2, 0, 0, 4096, 32'h0, 2'b01);
    add(3'd6, 0, 0, 0, 0, 0, -32'sd1048576, 32'h8000006F,
        2'b00);
    add(3'd6, 0, 0, 0, 0, 0, 1048575, 32'h0, 2'b10);
    add(3'd3, 31, 4, 3, 0, 0, -32'sd1, 32'hFE322FA3, 2'b00);
    add(3'd7, 1, 1, 1, 0, 0, 0, 32'h0, 2'b11);
    add(3'd1, 2, 3, 31, 0, 0, 16, 32'h01018113, 2'b00);
    add(3'd3, 0, 1, 2, 0, 0, -32'sd2049, 32'h0, 2'b01);
    add(3'd6, 0, 0, 0, 0, 0, 1048576, 32'h0, 2'b01);

    #12;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", {29'd0, full, err, err}, 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i], 1'b1);
      chk("count", 32'(count), 32'(exp_cnt));
      if (vecs[i].code != 2'b00) begin
        chk("err_no_we", 32'(imem_we), 32'd0);
        chk("err_flag", 32'(err), 32'd1);
        chk("err_code", 32'(err_code), 32'(vecs[i].code));
        do_clear();
      end else if (exp_cnt == 4) begin
        in_valid = 1'b0;
        chk("full_flag", 32'(full), 32'd1);
        chk("full_ready", 32'(in_ready), 32'd0);
        do_clear();
      end
    end
    idle();

    // first error cause stays latched
    do_clear();
    send(mk(3'd1, 1, 0, 0, 2048, 0, 2'b01), 1'b1);
    send(mk(3'd2, 1, 0, 0, 4096, 0, 2'b01), 1'b1);
    send(mk(3'd5, 0, 1, 2, 3, 0, 2'b10), 1'b1);
    chk("sticky_code", 32'(err_code), 32'd1);
    chk("sticky_cnt", 32'(count), 32'd0);
    send(mk(3'd1, 5, 0, 0, -32'sd1, 32'hFFF00293, 2'b00), 1'b1);
    chk("err_then_ok_cnt", 32'(count), 32'd1);
    chk("err_then_ok_code", 32'(err_code), 32'd1);
    idle();
    do_clear();

    // clear right after a write lets that write finish
    send(mk(3'd1, 5, 0, 0, -32'sd1, 32'hFFF00293, 2'b00), 1'b1);
    do_clear();
    chk("post_clr_sb", 32'(sb.size()), 32'd0);

    // stream 6 back-to-back into a 4-word memory
    for (int k = 1; k <= 6; k++) begin
      v = mk(3'd1, 5'(k), 0, 0, 32'(k),
             (32'(k) << 20) | (32'(k) << 7) | 32'h13, 2'b00);
      if (exp_cnt < 4) send(v, 1'b1);
      else drive(v);
    end
    chk("stream_full", 32'(full), 32'd1);
    chk("stream_ready", 32'(in_ready), 32'd0);
    chk("stream_count", 32'(count), 32'd4);
    idle();
    idle();
    chk("stream_sb", 32'(sb.size()), 32'd0);
    do_clear();

    // reset while a write is on the port
    drive(mk(3'd1, 5, 0, 0, -32'sd1, 32'hFFF00293, 2'b00));
    in_valid = 1'b0;
    chk("pre_rst_we", 32'(imem_we), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    chk("mid_rst_wdata", imem_wdata, 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    chk("final_sb", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
